// File: rtl/cpu_pkg.sv
// Shared types and default widths for the program-counter controller.
package cpu_pkg;

  localparam int unsigned PC_W_DEF  = 12;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Control/status bundle between the sequencer (master) and pc_ctrl (slave).
interface pc_ctrl_if import cpu_pkg::*; #(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             branch_en;
  logic             cond;
  logic [PC_W-1:0]  target;
  logic             halt;
  logic             stall;
  logic [PC_W-1:0]  prog_ctr;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic             wrap_err;

  modport master (
    output start, start_addr, branch_en, cond, target, halt, stall,
    input  prog_ctr, fetch_valid, done, cycle_cnt, wrap_err
  );

  modport slave (
    input  start, start_addr, branch_en, cond, target, halt, stall,
    output prog_ctr, fetch_valid, done, cycle_cnt, wrap_err
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over enable.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Count while enabled, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential fetch, taken branches with a one-cycle
// bubble, stall/halt handling, wrap detection and a saturating cycle counter.
module pc_ctrl import cpu_pkg::*; #(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic    clk,
  input  logic    reset,
  pc_ctrl_if.slave bus
);

  pc_state_e        state;
  pc_state_e        state_nxt;
  logic             start_acc;
  logic             do_halt;
  logic             do_branch;
  logic             do_inc;
  logic [PC_W-1:0]  prog_ctr_q;
  logic             done_q;
  logic             wrap_q;
  logic [CNT_W-1:0] cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: stall beats halt beats taken branch; BUBBLE ignores all inputs.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall)                      state_nxt = ST_RUN;
        else if (bus.halt)                  state_nxt = ST_IDLE;
        else if (bus.branch_en && bus.cond) state_nxt = ST_BUBBLE;
      end
      ST_BUBBLE: state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle datapath action, exactly one at most.
  always_comb begin
    start_acc = 1'b0;
    do_halt   = 1'b0;
    do_branch = 1'b0;
    do_inc    = 1'b0;
    case (state)
      ST_IDLE: start_acc = bus.start;
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt)                       do_halt   = 1'b1;
          else if (bus.branch_en && bus.cond) do_branch = 1'b1;
          else                                do_inc    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Program counter, done and sticky wrap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr_q <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (start_acc) begin
      prog_ctr_q <= bus.start_addr;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (do_halt) begin
      done_q <= 1'b1;
    end else if (do_branch) begin
      prog_ctr_q <= bus.target;
    end else if (do_inc) begin
      prog_ctr_q <= prog_ctr_q + PC_W'(1);
      if (&prog_ctr_q) wrap_q <= 1'b1;
    end
  end

  // Cycles spent in RUN or BUBBLE, restarted by each accepted start.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .clear  (reset | start_acc),
    .enable (state != ST_IDLE),
    .count  (cnt)
  );

  assign bus.prog_ctr    = prog_ctr_q;
  assign bus.fetch_valid = (state == ST_RUN) && !bus.stall;
  assign bus.done        = done_q;
  assign bus.cycle_cnt   = cnt;
  assign bus.wrap_err    = wrap_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl; a narrow-counter instance covers saturation.
module tb_pc_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_ctrl_if #(.PC_W(12), .CNT_W(16)) bus ();
  pc_ctrl_if #(.PC_W(12), .CNT_W(4))  bus_s ();

  pc_ctrl #(.PC_W(12), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_ctrl #(.PC_W(12), .CNT_W(4)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.start_addr = '0; bus.branch_en = 0; bus.cond = 0;
    bus.target = '0; bus.halt = 0; bus.stall = 0;
  endtask

  // Reset for one edge, then start at addr; returns one cycle into RUN.
  task automatic launch(input logic [11:0] addr);
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    bus.start = 1; bus.start_addr = addr;
    tick();
    bus.start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    checks++; if (bus.prog_ctr !== 12'd0) begin errors++; $display("FAIL rst_pc got=%0d exp=0", bus.prog_ctr); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fv got=%b exp=0", bus.fetch_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", bus.cycle_cnt); end
    checks++; if (bus.wrap_err !== 1'b0) begin errors++; $display("FAIL rst_wrap got=%b exp=0", bus.wrap_err); end
    reset = 0;
    tick();
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL idle_fv got=%b exp=0", bus.fetch_valid); end
  endtask

  task automatic test_sequential();
    launch(12'd5);
    checks++; if (bus.prog_ctr !== 12'd5 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_5 got=%0d/%b exp=5/1", bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL seq_cnt0 got=%0d exp=0", bus.cycle_cnt); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd6 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_6 got=%0d/%b exp=6/1", bus.prog_ctr, bus.fetch_valid); end
    bus.start = 1; bus.start_addr = 12'd100;
    tick();
    bus.start = 0;
    checks++; if (bus.prog_ctr !== 12'd7 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_7 got=%0d/%b exp=7/1", bus.prog_ctr, bus.fetch_valid); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd8) begin errors++; $display("FAIL start_ignored got=%0d exp=8", bus.prog_ctr); end
    checks++; if (bus.cycle_cnt !== 16'd3) begin errors++; $display("FAIL seq_cnt3 got=%0d exp=3", bus.cycle_cnt); end
  endtask

  task automatic test_branch();
    launch(12'd10);
    bus.branch_en = 1; bus.cond = 1; bus.target = 12'd323;
    tick();
    checks++; if (bus.prog_ctr !== 12'd323 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got=%0d/%b exp=323/0", bus.prog_ctr, bus.fetch_valid); end
    // Inputs during the bubble must be ignored.
    bus.branch_en = 1; bus.cond = 1; bus.target = 12'd50; bus.halt = 1; bus.stall = 1; bus.start = 1;
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.prog_ctr !== 12'd323 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL br_resume got=%0d/%b exp=323/1", bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL br_halt_ignored got=%b exp=0", bus.done); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd324 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL br_324 got=%0d/%b exp=324/1", bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.cycle_cnt !== 16'd3) begin errors++; $display("FAIL br_cnt got=%0d exp=3", bus.cycle_cnt); end
    bus.branch_en = 1; bus.cond = 0; bus.target = 12'd0;
    tick();
    checks++; if (bus.prog_ctr !== 12'd325 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL br_not_taken got=%0d/%b exp=325/1", bus.prog_ctr, bus.fetch_valid); end
    bus.cond = 1; bus.target = 12'd325;
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.prog_ctr !== 12'd325 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL br_self got=%0d/%b exp=325/0", bus.prog_ctr, bus.fetch_valid); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd325 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL br_self_resume got=%0d/%b exp=325/1", bus.prog_ctr, bus.fetch_valid); end
  endtask

  task automatic test_stall();
    launch(12'd20);
    bus.stall = 1; bus.halt = 1; bus.branch_en = 1; bus.cond = 1; bus.target = 12'd99;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv got=%b exp=0", bus.fetch_valid); end
    tick(); tick(); tick();
    checks++; if (bus.prog_ctr !== 12'd20 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_hold got=%0d/%b exp=20/0", bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.cycle_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", bus.cycle_cnt); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_halt_ignored got=%b exp=0", bus.done); end
    clear_inputs();
    #1;
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", bus.fetch_valid); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd21 || bus.cycle_cnt !== 16'd4) begin errors++; $display("FAIL stall_after got=%0d/%0d exp=21/4", bus.prog_ctr, bus.cycle_cnt); end
  endtask

  task automatic test_halt();
    launch(12'd620);
    bus.halt = 1;
    tick();
    bus.halt = 0;
    checks++; if (bus.done !== 1'b1 || bus.prog_ctr !== 12'd620 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt got=%b/%0d/%b exp=1/620/0", bus.done, bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.cycle_cnt !== 16'd1) begin errors++; $display("FAIL halt_cnt got=%0d exp=1", bus.cycle_cnt); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.cycle_cnt !== 16'd1 || bus.prog_ctr !== 12'd620) begin errors++; $display("FAIL halt_hold got=%b/%0d/%0d exp=1/1/620", bus.done, bus.cycle_cnt, bus.prog_ctr); end
    bus.start = 1; bus.start_addr = 12'd3;
    tick();
    bus.start = 0;
    checks++; if (bus.done !== 1'b0 || bus.prog_ctr !== 12'd3 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL restart got=%b/%0d/%b exp=0/3/1", bus.done, bus.prog_ctr, bus.fetch_valid); end
    checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt got=%0d exp=0", bus.cycle_cnt); end
  endtask

  task automatic test_wrap_reset();
    launch(12'd4094);
    checks++; if (bus.prog_ctr !== 12'd4094 || bus.wrap_err !== 1'b0) begin errors++; $display("FAIL wrap_4094 got=%0d/%b exp=4094/0", bus.prog_ctr, bus.wrap_err); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd4095 || bus.wrap_err !== 1'b0) begin errors++; $display("FAIL wrap_4095 got=%0d/%b exp=4095/0", bus.prog_ctr, bus.wrap_err); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd0 || bus.wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_0 got=%0d/%b exp=0/1", bus.prog_ctr, bus.wrap_err); end
    tick();
    checks++; if (bus.prog_ctr !== 12'd1 || bus.wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_sticky got=%0d/%b exp=1/1", bus.prog_ctr, bus.wrap_err); end
    reset = 1; bus.start = 1; bus.start_addr = 12'd77; bus.halt = 1;
    tick();
    reset = 0; clear_inputs();
    #1;
    checks++; if (bus.prog_ctr !== 12'd0 || bus.fetch_valid !== 1'b0 || bus.done !== 1'b0 || bus.cycle_cnt !== 16'd0 || bus.wrap_err !== 1'b0)
      begin errors++; $display("FAIL run_reset got pc=%0d fv=%b done=%b cnt=%0d wrap=%b exp 0/0/0/0/0", bus.prog_ctr, bus.fetch_valid, bus.done, bus.cycle_cnt, bus.wrap_err); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b0 || bus.prog_ctr !== 12'd0) begin errors++; $display("FAIL post_reset_idle got=%b/%0d exp=0/0", bus.fetch_valid, bus.prog_ctr); end
  endtask

  task automatic test_bubble_reset();
    launch(12'd10);
    bus.branch_en = 1; bus.cond = 1; bus.target = 12'd200;
    tick();
    clear_inputs();
    reset = 1; bus.start = 1; bus.start_addr = 12'd9;
    tick();
    reset = 0; clear_inputs();
    #1;
    checks++; if (bus.prog_ctr !== 12'd0 || bus.fetch_valid !== 1'b0 || bus.cycle_cnt !== 16'd0)
      begin errors++; $display("FAIL bubble_reset got=%0d/%b/%0d exp=0/0/0", bus.prog_ctr, bus.fetch_valid, bus.cycle_cnt); end
  endtask

  task automatic test_saturation();
    bus_s.start = 0; bus_s.start_addr = '0; bus_s.branch_en = 0; bus_s.cond = 0;
    bus_s.target = '0; bus_s.halt = 0; bus_s.stall = 0;
    reset = 1;
    tick();
    reset = 0;
    bus_s.start = 1;
    tick();
    bus_s.start = 0;
    repeat (20) tick();
    checks++; if (bus_s.cycle_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", bus_s.cycle_cnt); end
    checks++; if (bus_s.prog_ctr !== 12'd20 || bus_s.fetch_valid !== 1'b1) begin errors++; $display("FAIL sat_pc got=%0d/%b exp=20/1", bus_s.prog_ctr, bus_s.fetch_valid); end
    bus_s.halt = 1;
    tick();
    bus_s.halt = 0;
    checks++; if (bus_s.cycle_cnt !== 4'd15 || bus_s.done !== 1'b1) begin errors++; $display("FAIL sat_halt got=%0d/%b exp=15/1", bus_s.cycle_cnt, bus_s.done); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1;
    clear_inputs();
    bus_s.start = 0; bus_s.start_addr = '0; bus_s.branch_en = 0; bus_s.cond = 0;
    bus_s.target = '0; bus_s.halt = 0; bus_s.stall = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_wrap_reset();
    test_bubble_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
